// File: rtl/ripple_carry_adder_pkg.sv
// ripple_carry_adder_pkg
//   Shared constants for the ripple-carry adder slice. The adder has no
//   typedefs; the only shared item is the default operand width so that
//   instantiating blocks and the top agree on one value.
//   Ports: none (package).
package ripple_carry_adder_pkg;

  // Default operand/sum width of the adder.
  localparam int RCA_DEFAULT_WIDTH = 4;

endpackage : ripple_carry_adder_pkg

// File: rtl/ripple_carry_adder_full_adder.sv
// full_adder
//   Purely combinational 1-bit full adder, the cell of the ripple chain.
//   Ports:
//     a, b  in   operand bits
//     cin   in   carry in
//     sum   out  a ^ b ^ cin
//     cout  out  generate | (propagate & cin)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p_s;

  // Propagate term shared by the sum and the carry.
  assign p_s  = a ^ b;
  assign sum  = p_s ^ cin;
  assign cout = (a & b) | (cin & p_s);

endmodule : full_adder

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder
//   WIDTH-bit registered ripple-carry adder: {cout,sum} = a + b + cin,
//   one cycle of latency, one result per cycle. The carry ripples through
//   WIDTH chained full_adder cells; no '+' and no lookahead.
//   Optional macro: RIPPLE_CARRY_ADDER_OVF_EN adds a registered signed
//   overflow output ovf = c[WIDTH] ^ c[WIDTH-1].
//   Ports:
//     clk   in   sole clock, rising edge
//     rst   in   asynchronous active-high reset, clears all outputs
//     a, b  in   WIDTH-bit unsigned operands
//     cin   in   carry into bit 0
//     sum   out  registered low WIDTH bits of a+b+cin
//     cout  out  registered carry out of the top bit
//     ovf   out  registered two's-complement overflow (macro builds only)
module ripple_carry_adder
  import ripple_carry_adder_pkg::*;
#(
  parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // c_s[i] is the carry into bit i; c_s[WIDTH] is the final carry out.
  logic [WIDTH:0]   c_s;
  logic [WIDTH-1:0] s_s;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;

  assign c_s[0] = cin;

  // Carry chain: each cell consumes the carry produced by the cell below.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c_s[i]),
      .sum  (s_s[i]),
      .cout (c_s[i+1])
    );
  end

  // Next-state values for the output registers.
  always_comb begin
    sum_d  = s_s;
    cout_d = c_s[WIDTH];
  end

  // Output registers; reset clears them without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef RIPPLE_CARRY_ADDER_OVF_EN
  logic ovf_d, ovf_q;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_comb begin
    ovf_d = c_s[WIDTH] ^ c_s[WIDTH-1];
  end

  // Overflow register, cleared together with sum/cout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule : ripple_carry_adder

// File: tb/tb_ripple_carry_adder.sv
// tb_ripple_carry_adder
//   Directed and exhaustive checks of the registered ripple-carry adder at
//   WIDTH=4, plus random checks of WIDTH=16 and WIDTH=1 instances.
module tb_ripple_carry_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  a, b, sum;
  logic        cin, cout;
  logic [15:0] a16, b16, sum16;
  logic        cin16, cout16;
  logic        a1, b1, cin1, sum1, cout1;
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
  logic        ovf, ovf16, ovf1;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ripple_carry_adder #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout)
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  ripple_carry_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16), .sum(sum16), .cout(cout16)
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
    , .ovf(ovf16)
`endif
  );

  ripple_carry_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .sum(sum1), .cout(cout1)
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifdef RIPPLE_CARRY_ADDER_OVF_EN
  // Signed-range model of overflow for a w-bit two's-complement add.
  function automatic logic ovf_ref(input int w, input longint ua, input longint ub, input int c);
    longint lim, sa, sb, r;
    lim = longint'(1) << (w - 1);
    sa  = (ua >= lim) ? ua - 2 * lim : ua;
    sb  = (ub >= lim) ? ub - 2 * lim : ub;
    r   = sa + sb + longint'(c);
    return (r >= lim) || (r < -lim);
  endfunction
`endif

  // Drive one vector at the falling edge, check the registered result after the next rise.
  task automatic step4(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                       input logic tc, input logic [3:0] es, input logic ec, input logic eo);
    @(negedge clk);
    a = ta; b = tb; cin = tc;
    @(posedge clk);
    #1;
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("unexpected X in overflow table for %s", tag);
`endif
  endtask

  initial begin
    logic [8:0]  v;
    logic [4:0]  exp_prev;
    logic [16:0] e16;
    logic [1:0]  e1;

    rst = 1'b0;
    a = 4'hF; b = 4'hF; cin = 1'b1;
    a16 = 16'h0000; b16 = 16'h0000; cin16 = 1'b0;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;

    // Load a nonzero result, then reset between edges.
    @(posedge clk); #1;
    check("ones_cin_sum", 32'(sum), 32'h0000_000F);
    check("ones_cin_cout", 32'(cout), 32'h0000_0001);
    #1 rst = 1'b1;
    #1;
    check("async_rst_sum", 32'(sum), 32'h0000_0000);
    check("async_rst_cout", 32'(cout), 32'h0000_0000);
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
    check("async_rst_ovf", 32'(ovf), 32'h0000_0000);
`endif
    @(posedge clk); #1;
    check("rst_hold_sum", 32'(sum), 32'h0000_0000);
    check("rst_hold_cout", 32'(cout), 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_noedge_sum", 32'(sum), 32'h0000_0000);
    check("rel_noedge_cout", 32'(cout), 32'h0000_0000);
    @(posedge clk); #1;
    check("first_cap_sum", 32'(sum), 32'h0000_000F);
    check("first_cap_cout", 32'(cout), 32'h0000_0001);

    // Directed vectors: a, b, cin -> sum, cout, ovf.
    step4("basic0", 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0);
    step4("basic1", 4'b0010, 4'b1000, 1'b0, 4'b1010, 1'b0, 1'b0);
    step4("cin0",   4'b1000, 4'b0011, 1'b1, 4'b1100, 1'b0, 1'b0);
    step4("cin1",   4'b0101, 4'b0111, 1'b1, 4'b1101, 1'b0, 1'b1);
    step4("wrap0",  4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
    step4("wrap1",  4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0);
    step4("ovf_p",  4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
    step4("ovf_n",  4'b1001, 4'b0010, 1'b0, 4'b1011, 1'b0, 1'b0);

    // Mid-stream reset: the vector driven before reset must never appear.
    @(negedge clk);
    a = 4'b0011; b = 4'b0100; cin = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_sum", 32'(sum), 32'h0000_0000);
    check("mid_rst_cout", 32'(cout), 32'h0000_0000);
    @(posedge clk); #1;
    check("mid_rst_hold", 32'({cout, sum}), 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;
    a = 4'b0001; b = 4'b0001; cin = 1'b0;
    @(posedge clk); #1;
    check("post_rst", 32'({cout, sum}), 32'h0000_0002);

    // Exhaustive, new inputs every cycle: old result until the edge, new one after.
    exp_prev = 5'b00010;
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      @(negedge clk);
      a = v[8:5]; b = v[4:1]; cin = v[0];
      #1;
      check("exh_lag", 32'({cout, sum}), 32'(exp_prev));
      @(posedge clk); #1;
      exp_prev = 5'({1'b0, v[8:5]}) + 5'({1'b0, v[4:1]}) + 5'(v[0]);
      check("exh_res", 32'({cout, sum}), 32'(exp_prev));
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
      check("exh_ovf", 32'(ovf), 32'(ovf_ref(4, longint'(v[8:5]), longint'(v[4:1]), int'(v[0]))));
`endif
    end

    // Random checks of the 16-bit and 1-bit builds.
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      if (i == 0) begin a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1; end
      a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
      e16 = 17'({1'b0, a16}) + 17'({1'b0, b16}) + 17'(cin16);
      e1  = 2'({1'b0, a1}) + 2'({1'b0, b1}) + 2'(cin1);
      @(posedge clk); #1;
      check("w16_res", 32'({cout16, sum16}), 32'(e16));
      check("w1_res", 32'({cout1, sum1}), 32'(e1));
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
      check("w16_ovf", 32'(ovf16), 32'(ovf_ref(16, longint'(a16), longint'(b16), int'(cin16))));
      check("w1_ovf", 32'(ovf1), 32'(ovf_ref(1, longint'(a1), longint'(b1), int'(cin1))));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_ripple_carry_adder
